// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one full-subtractor cell and a registered borrow
//
// Purpose:
//   Computes {bout, diff} = a - b - bin one bit per clock, LSB first.
//   A start accepted while idle loads the operands; WIDTH edges later the
//   result registers update and done pulses for one cycle.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous, active-high reset
//   start  in   request, sampled only while busy=0
//   a      in   [WIDTH] minuend, captured on the accepting edge
//   b      in   [WIDTH] subtrahend, captured with a
//   bin    in   borrow-in, captured with a
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse, diff/bout newly updated
//   diff   out  [WIDTH] (a - b - bin) mod 2^WIDTH
//   bout   out  borrow-out, 1 iff a < b + bin (unsigned)

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_opa_sh;
  logic [WIDTH-1:0] r_opb_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_x;
  logic             w_y;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs and the running borrow.
  assign w_x       = r_opa_sh[0];
  assign w_y       = r_opb_sh[0];
  assign w_d       = w_x ^ w_y ^ r_br;
  assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);

  // New difference bit enters at the MSB; shift form keeps WIDTH=1 legal.
  assign w_res_next = (r_res_sh >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; done/diff/bout come straight from registers.
  always_comb begin
    busy = (r_state == S_SHIFT);
  end

  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

  // Datapath: operand shifters, result shifter, borrow, bit counter and
  // the result registers that only change on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa_sh <= '0;
      r_opb_sh <= '0;
      r_res_sh <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa_sh <= a;
            r_opb_sh <= b;
            r_br     <= bin;
            r_res_sh <= '0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_opa_sh <= r_opa_sh >> 1;
          r_opb_sh <= r_opb_sh >> 1;
          r_res_sh <= w_res_next;
          r_br     <= w_br_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_br_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
